mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between two requesters: the multicycle core (port C: fetch and load/store) and the program loader/debug port (port D).
- Serialises accesses, drives the memory for a fixed LAT-cycle access window, and returns read data with a one-cycle ack pulse.
- Applies round-robin arbitration on contention and keeps a saturating count of core wait cycles for bring-up debug.

Parameters:
- AW, 32, address width
- DW, 32, data width
- LAT, 2, memory access cycles per transaction (must be >= 1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- c_req  in  1  core request; held high until c_ack
- c_we  in  1  core write enable (1 = write)
- c_addr  in  AW  core address
- c_wdata  in  DW  core write data
- c_ack  out  1  core completion pulse
- c_rdata  out  DW  core read data; valid while c_ack = 1
- d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  loader request group, same rules as core
- d_ack  out  1  loader completion pulse
- d_rdata  out  DW  loader read data; valid while d_ack = 1
- mem_en  out  1  memory enable
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high whenever state != IDLE
- grant_id  out  1  owner of the current or last transaction (0 = core, 1 = loader)
- c_wait_cnt  out  16  core wait cycles, saturating

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low. All outputs are registered.
- Reset values: state IDLE, c_ack = 0, d_ack = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, c_rdata = 0, d_rdata = 0, busy = 0, grant_id = 1 (core wins the first contention), c_wait_cnt = 0, internal cnt = 0.
- IDLE:
  - Samples c_req and d_req at each edge.
  - One request: grant it.
  - Both requests: grant the port != grant_id.
  - On grant: latch addr, we and wdata into mem_addr, mem_we and mem_wdata; set mem_en = 1; set grant_id; set cnt = LAT-1; go to ACCESS.
  - No request: stay in IDLE with mem_en = 0.
- ACCESS:
  - mem_en and mem_addr are held stable for exactly LAT cycles.
  - mem_we is high only in the first ACCESS cycle and cleared after it.
  - Each edge: if cnt == 0, latch mem_rdata into the granted port's rdata and go to RESP; else decrement cnt.
- RESP:
  - The granted port's ack is 1 for exactly one cycle; mem_en = 0; next state is IDLE.
  - Writes also ack, and rdata is updated with mem_rdata for writes too (value don't-care for the requester).
- Latency: ack rises LAT+1 edges after the accepting edge. Minimum spacing between grants is LAT+2 cycles.
- Requester contract:
  - req, we, addr and wdata are registered and held until ack is seen.
  - Req is dropped or changed at the edge that ends the ack cycle, so IDLE never re-samples a completed request.
  - A requester that keeps req high after ack issues a new transaction.
- Req dropped mid-transaction (protocol violation): the transaction still completes and ack still pulses. There is no abort.
- Request from the non-granted port during ACCESS or RESP: ignored until IDLE. Round-robin then guarantees it is granted next if both ports are requesting.
- c_wait_cnt: increments every cycle in which c_req = 1 and the core is not in its own ACCESS or RESP. Saturates at 16'hFFFF and never wraps.
- Reset mid-transaction: immediate return to reset values. The transaction is lost with no ack, and requesters re-issue.

Test Plan:
- Single core read, LAT = 2, mem returns 32'hDEADBEEF, c_req sampled at edge 1:
  - mem_en high for cycles after edges 1–2.
  - c_ack high only in the cycle after edge 3, with c_rdata = 32'hDEADBEEF.
  - d_ack stays 0.
- Loader write, addr 32'h40, data 32'h1234:
  - mem_we = 1 only in the first ACCESS cycle, with mem_addr = 32'h40 and mem_wdata = 32'h1234.
  - d_ack pulses once; grant_id = 1.
- Contention, both req high from reset and held:
  - Grant order is core, loader, core, loader.
  - Each ack is separated by LAT+2 = 4 cycles; grant_id alternates 0, 1, 0, 1.
- Core waiting behind a loader transaction:
  - c_wait_cnt increases by exactly the number of cycles c_req was high before its grant (3 for a grant that lands right after the loader ack).
  - Forcing 70000 wait cycles yields c_wait_cnt = 16'hFFFF.
- rst_n pulsed low during the second ACCESS cycle:
  - All outputs return to reset values asynchronously; no ack is ever issued for that request.
  - After release, a re-issued request completes normally.
- LAT = 1 build:
  - Single read acks 2 edges after acceptance, with mem_en high for exactly one cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the core (C) and loader (D).
// Latency: ack LAT+1 edges after grant; backpressure: requests hold until ack, losers wait in IDLE.
module mem_port_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_id,
  output logic [15:0]   c_wait_cnt
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;

  logic w_any_req;
  logic w_pick_d;
  logic w_core_owns;
  logic w_wait_inc;

  // On contention the port that did not own the last transaction wins.
  assign w_any_req   = c_req | d_req;
  assign w_pick_d    = d_req & (~c_req | ~grant_id);
  assign w_core_owns = (r_state != IDLE) & ~grant_id;
  assign w_wait_inc  = c_req & ~w_core_owns & (c_wait_cnt != 16'hFFFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      c_ack      <= 1'b0;
      d_ack      <= 1'b0;
      c_rdata    <= '0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      grant_id   <= 1'b1;
      c_wait_cnt <= '0;
    end else begin
      c_ack <= 1'b0;
      d_ack <= 1'b0;
      if (w_wait_inc) c_wait_cnt <= c_wait_cnt + 16'd1;

      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            grant_id  <= w_pick_d;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            mem_we    <= w_pick_d ? d_we    : c_we;
            mem_addr  <= w_pick_d ? d_addr  : c_addr;
            mem_wdata <= w_pick_d ? d_wdata : c_wdata;
            r_cnt     <= CW'(LAT - 1);
            r_state   <= ACCESS;
          end
        end
        ACCESS: begin
          // Write strobe lives only in the first access cycle.
          mem_we <= 1'b0;
          if (r_cnt == '0) begin
            if (grant_id) begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end else begin
              c_rdata <= mem_rdata;
              c_ack   <= 1'b1;
            end
            mem_en  <= 1'b0;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: LAT=2 main instance, LAT=1 instance, long-LAT saturation instance.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SAT_LAT = 65540;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic c_req, c_we, c_ack, d_req, d_we, d_ack;
  logic [AW-1:0] c_addr, d_addr, mem_addr;
  logic [DW-1:0] c_wdata, c_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic mem_en, mem_we, busy, grant_id;
  logic [15:0] c_wait_cnt;

  logic l1_c_req, l1_c_ack, l1_d_ack, l1_mem_en, l1_mem_we, l1_busy, l1_grant_id;
  logic [AW-1:0] l1_c_addr, l1_mem_addr;
  logic [DW-1:0] l1_c_rdata, l1_d_rdata, l1_mem_wdata;
  logic [15:0] l1_c_wait_cnt;

  logic s_c_req, s_d_req, s_c_ack, s_d_ack, s_mem_en, s_mem_we, s_busy, s_grant_id;
  logic [AW-1:0] s_c_addr, s_mem_addr;
  logic [DW-1:0] s_c_wdata, s_c_rdata, s_d_rdata, s_mem_wdata;
  logic [15:0] s_c_wait_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] q_c[$];
  logic [DW-1:0] q_d[$];

  // Memory model: unwritten words read as DEADBEEF + (addr - 0x10).
  logic [DW-1:0] mem_arr [0:255];
  bit   [255:0]  mem_wr;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem_arr[mem_addr[7:0]] <= mem_wdata;
      mem_wr[mem_addr[7:0]]  <= 1'b1;
    end
  end
  assign mem_rdata = mem_wr[mem_addr[7:0]] ? mem_arr[mem_addr[7:0]]
                                           : 32'hDEADBEEF + mem_addr - 32'h10;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id), .c_wait_cnt(c_wait_cnt)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n),
    .c_req(l1_c_req), .c_we(1'b0), .c_addr(l1_c_addr), .c_wdata(32'h0), .c_ack(l1_c_ack), .c_rdata(l1_c_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_ack(l1_d_ack), .d_rdata(l1_d_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(32'hA5A50001),
    .busy(l1_busy), .grant_id(l1_grant_id), .c_wait_cnt(l1_c_wait_cnt)
  );

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(SAT_LAT)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .c_req(s_c_req), .c_we(1'b0), .c_addr(s_c_addr), .c_wdata(s_c_wdata), .c_ack(s_c_ack), .c_rdata(s_c_rdata),
    .d_req(s_d_req), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_ack(s_d_ack), .d_rdata(s_d_rdata),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(32'h00005A5A),
    .busy(s_busy), .grant_id(s_grant_id), .c_wait_cnt(s_c_wait_cnt)
  );

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    l1_c_req = 0; l1_c_addr = 0;
    s_c_req = 0; s_d_req = 0; s_c_addr = 0; s_c_wdata = 0;
    q_c.delete(); q_d.delete();
    nclk(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({c_ack, d_ack, mem_en, mem_we, busy, grant_id} !== 6'b000001) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 000001", {c_ack, d_ack, mem_en, mem_we, busy, grant_id});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, c_rdata, d_rdata} !== 128'h0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, c_rdata, d_rdata});
    end
    n_cmp++;
    if (c_wait_cnt !== 16'h0) begin
      n_err++; $display("FAIL reset_wait: got %h want 0000", c_wait_cnt);
    end
  endtask

  task automatic test_core_read();
    logic [DW-1:0] e;
    c_we = 0; c_addr = 32'h10; c_req = 1; q_c.push_back(32'hDEADBEEF);
    nclk(1);
    n_cmp++;
    if ({mem_en, mem_we, busy, grant_id} !== 4'b1010 || mem_addr !== 32'h10) begin
      n_err++; $display("FAIL core_rd_acc1: got en/we/busy/gid=%b addr=%h want 1010 addr=10", {mem_en, mem_we, busy, grant_id}, mem_addr);
    end
    nclk(1);
    n_cmp++;
    if ({mem_en, c_ack} !== 2'b10) begin
      n_err++; $display("FAIL core_rd_acc2: got en/ack=%b want 10", {mem_en, c_ack});
    end
    nclk(1);
    n_cmp++;
    if ({c_ack, d_ack, mem_en} !== 3'b100) begin
      n_err++; $display("FAIL core_rd_ack: got cack/dack/en=%b want 100", {c_ack, d_ack, mem_en});
    end
    e = (q_c.size() > 0) ? q_c.pop_front() : 32'hx;
    n_cmp++;
    if (c_rdata !== e) begin
      n_err++; $display("FAIL core_rd_data: got %h want %h", c_rdata, e);
    end
    c_req = 0;
    nclk(1);
    n_cmp++;
    if ({c_ack, busy} !== 2'b00) begin
      n_err++; $display("FAIL core_rd_done: got ack/busy=%b want 00", {c_ack, busy});
    end
  endtask

  task automatic test_loader_write();
    logic [DW-1:0] e;
    d_we = 1; d_addr = 32'h40; d_wdata = 32'h1234; d_req = 1; q_d.push_back(32'h1234);
    nclk(1);
    n_cmp++;
    if ({mem_en, mem_we, grant_id} !== 3'b111 || mem_addr !== 32'h40 || mem_wdata !== 32'h1234) begin
      n_err++; $display("FAIL ld_wr_acc1: got en/we/gid=%b addr=%h wdata=%h want 111 40 1234", {mem_en, mem_we, grant_id}, mem_addr, mem_wdata);
    end
    nclk(1);
    n_cmp++;
    if ({mem_en, mem_we} !== 2'b10) begin
      n_err++; $display("FAIL ld_wr_acc2: got en/we=%b want 10", {mem_en, mem_we});
    end
    nclk(1);
    e = (q_d.size() > 0) ? q_d.pop_front() : 32'hx;
    n_cmp++;
    if ({d_ack, c_ack} !== 2'b10 || d_rdata !== e) begin
      n_err++; $display("FAIL ld_wr_ack: got dack/cack=%b rdata=%h want 10 %h", {d_ack, c_ack}, d_rdata, e);
    end
    d_req = 0; d_we = 0;
    nclk(1);
    n_cmp++;
    if ({d_ack, grant_id} !== 2'b01) begin
      n_err++; $display("FAIL ld_wr_done: got dack/gid=%b want 01", {d_ack, grant_id});
    end
  endtask

  task automatic test_contention();
    int exp_cyc [4] = '{3, 7, 11, 15};
    logic exp_port [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int k = 0;
    logic [DW-1:0] e;
    do_reset();
    c_addr = 32'h10; d_addr = 32'h40;
    q_c.push_back(32'hDEADBEEF); q_c.push_back(32'hDEADBEEF);
    q_d.push_back(32'h1234);     q_d.push_back(32'h1234);
    c_req = 1; d_req = 1;
    for (int i = 1; i <= 20; i++) begin
      nclk(1);
      if (c_ack || d_ack) begin
        n_cmp++;
        if (k >= 4) begin
          n_err++; $display("FAIL contention_extra: got ack at cycle %0d want none", i);
        end else begin
          if (exp_port[k]) e = (q_d.size() > 0) ? q_d.pop_front() : 32'hx;
          else             e = (q_c.size() > 0) ? q_c.pop_front() : 32'hx;
          if (i != exp_cyc[k] || {d_ack, c_ack} !== {exp_port[k], ~exp_port[k]} || grant_id !== exp_port[k]
              || (exp_port[k] ? d_rdata : c_rdata) !== e) begin
            n_err++;
            $display("FAIL contention_%0d: got cyc=%0d dack/cack=%b gid=%b want cyc=%0d port=%b rdata want %h",
                     k, i, {d_ack, c_ack}, grant_id, exp_cyc[k], exp_port[k], e);
          end
          if (k == 2) c_req = 0;
          if (k == 3) d_req = 0;
        end
        k++;
      end
    end
    n_cmp++;
    if (k != 4) begin
      n_err++; $display("FAIL contention_count: got %0d acks want 4", k);
    end
  endtask

  task automatic test_wait_cnt();
    logic [DW-1:0] e;
    do_reset();
    d_addr = 32'h40; d_req = 1; q_d.push_back(32'h1234);
    nclk(2);
    c_addr = 32'h10; c_req = 1; q_c.push_back(32'hDEADBEEF);
    nclk(1);
    e = (q_d.size() > 0) ? q_d.pop_front() : 32'hx;
    n_cmp++;
    if (d_ack !== 1'b1 || d_rdata !== e || c_wait_cnt !== 16'd1) begin
      n_err++; $display("FAIL wait_ldack: got dack=%b rdata=%h wait=%0d want 1 %h 1", d_ack, d_rdata, c_wait_cnt, e);
    end
    d_req = 0;
    nclk(2);
    n_cmp++;
    if (c_wait_cnt !== 16'd3 || {mem_en, grant_id} !== 2'b10) begin
      n_err++; $display("FAIL wait_grant: got wait=%0d en/gid=%b want 3 10", c_wait_cnt, {mem_en, grant_id});
    end
    nclk(2);
    e = (q_c.size() > 0) ? q_c.pop_front() : 32'hx;
    n_cmp++;
    if (c_ack !== 1'b1 || c_rdata !== e || c_wait_cnt !== 16'd3) begin
      n_err++; $display("FAIL wait_cack: got ack=%b rdata=%h wait=%0d want 1 %h 3", c_ack, c_rdata, c_wait_cnt, e);
    end
    c_req = 0;
    nclk(1);
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e;
    bit seen = 0;
    c_addr = 32'h10; c_req = 1;
    nclk(2);
    #1 rst_n = 0; c_req = 0;
    #1;
    n_cmp++;
    if ({c_ack, d_ack, mem_en, mem_we, busy, grant_id} !== 6'b000001 ||
        {mem_addr, mem_wdata, c_rdata, d_rdata} !== 128'h0 || c_wait_cnt !== 16'h0) begin
      n_err++; $display("FAIL rst_mid: got ctl=%b addr=%h crd=%h wait=%h want 000001 0 0 0",
                        {c_ack, d_ack, mem_en, mem_we, busy, grant_id}, mem_addr, c_rdata, c_wait_cnt);
    end
    #1 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      nclk(1);
      n_cmp++;
      if ({c_ack, busy} !== 2'b00) begin
        n_err++; $display("FAIL rst_mid_noack: got ack/busy=%b want 00", {c_ack, busy});
      end
    end
    c_req = 1; q_c.push_back(32'hDEADBEEF);
    for (int i = 1; i <= 10 && !seen; i++) begin
      nclk(1);
      if (c_ack) begin
        seen = 1;
        e = (q_c.size() > 0) ? q_c.pop_front() : 32'hx;
        n_cmp++;
        if (i != 3 || c_rdata !== e) begin
          n_err++; $display("FAIL rst_reissue: got cyc=%0d rdata=%h want 3 %h", i, c_rdata, e);
        end
        c_req = 0;
      end
    end
    if (!seen) begin
      n_cmp++; n_err++; $display("FAIL rst_reissue_timeout: got no ack want ack");
    end
    nclk(1);
  endtask

  task automatic test_lat1();
    l1_c_addr = 32'h8; l1_c_req = 1;
    nclk(1);
    n_cmp++;
    if ({l1_mem_en, l1_c_ack, l1_mem_we, l1_grant_id} !== 4'b1000 || l1_mem_addr !== 32'h8) begin
      n_err++; $display("FAIL lat1_acc: got en/ack/we/gid=%b addr=%h want 1000 8", {l1_mem_en, l1_c_ack, l1_mem_we, l1_grant_id}, l1_mem_addr);
    end
    nclk(1);
    n_cmp++;
    if ({l1_mem_en, l1_c_ack, l1_d_ack} !== 3'b010 || l1_c_rdata !== 32'hA5A50001) begin
      n_err++; $display("FAIL lat1_ack: got en/cack/dack=%b rdata=%h want 010 a5a50001", {l1_mem_en, l1_c_ack, l1_d_ack}, l1_c_rdata);
    end
    l1_c_req = 0;
    nclk(1);
    n_cmp++;
    if ({l1_c_ack, l1_busy} !== 2'b00 || l1_d_rdata !== 32'h0 || l1_mem_wdata !== 32'h0 || l1_c_wait_cnt !== 16'd1) begin
      n_err++; $display("FAIL lat1_done: got ack/busy=%b drd=%h wd=%h wait=%0d want 00 0 0 1",
                        {l1_c_ack, l1_busy}, l1_d_rdata, l1_mem_wdata, l1_c_wait_cnt);
    end
  endtask

  task automatic test_saturation();
    bit seen = 0;
    s_d_req = 1;
    nclk(1);
    s_c_addr = 32'h80; s_c_wdata = 32'h77; s_c_req = 1;
    for (int i = 0; i < 70000 && !seen; i++) begin
      nclk(1);
      if (s_d_ack) seen = 1;
    end
    n_cmp++;
    if (!seen || s_c_wait_cnt !== 16'hFFFF || s_d_rdata !== 32'h5A5A) begin
      n_err++; $display("FAIL sat_ldack: got seen=%b wait=%h drd=%h want 1 ffff 5a5a", seen, s_c_wait_cnt, s_d_rdata);
    end
    s_d_req = 0;
    nclk(2);
    n_cmp++;
    if (s_c_wait_cnt !== 16'hFFFF || {s_mem_en, s_busy, s_c_ack, s_mem_we, s_grant_id} !== 5'b11000 ||
        s_mem_addr !== 32'h80 || s_mem_wdata !== 32'h77 || s_c_rdata !== 32'h0) begin
      n_err++; $display("FAIL sat_nowrap: got wait=%h ctl=%b addr=%h wd=%h crd=%h want ffff 11000 80 77 0",
                        s_c_wait_cnt, {s_mem_en, s_busy, s_c_ack, s_mem_we, s_grant_id}, s_mem_addr, s_mem_wdata, s_c_rdata);
    end
    s_c_req = 0;
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_loader_write();
    test_contention();
    test_wait_cnt();
    test_reset_mid();
    test_lat1();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
